// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioning block: channel FSM encoding,
// direction indices and default timing.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DIR_L    = 0;
  localparam int DIR_R    = 1;
  localparam int DIR_U    = 2;
  localparam int DIR_D    = 3;
  localparam int NUM_DIRS = 4;

  // 100 MHz clock: 10 ms debounce, 500 ms before the first repeat, 200 ms between repeats
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam bit DEF_REPEAT_EN       = 1'b1;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, press/release debounce and
// a single-cycle pulse per accepted press plus optional auto-repeat.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | released, level 0, waiting for synced input to go high
// PRESS_WAIT   | input high, counting debounce before accepting the press
// HELD         | press accepted, level 1, repeat timer running
// RELEASE_WAIT | input low, counting debounce before accepting the release
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rpt;
  logic             rpt_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign sync = sync_q[1];

  // rpt_phase 0: waiting out the initial repeat delay; 1: periodic repeats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rpt       <= '0;
      rpt_phase <= 1'b0;
      pulse     <= 1'b0;
      level     <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            level     <= 1'b1;
            pulse     <= 1'b1;
            rpt       <= '0;
            rpt_phase <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (REPEAT_EN) begin
            if (rpt == (rpt_phase ? RP_LAST : RD_LAST)) begin
              pulse     <= 1'b1;
              rpt       <= '0;
              rpt_phase <= 1'b1;
            end else begin
              rpt <= rpt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          // a bounce back to high resumes the hold without a new move pulse
          if (sync) begin
            state     <= HELD;
            rpt       <= '0;
            rpt_phase <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Conditions the four directional pushbuttons into one-cycle move pulses and
// debounced held levels for the grid-sprite renderer.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l_raw,
  input  logic       btn_r_raw,
  input  logic       btn_u_raw,
  input  logic       btn_d_raw,
  output logic       btn_l,
  output logic       btn_r,
  output logic       btn_u,
  output logic       btn_d,
  output logic [3:0] btn_level
);

  logic [NUM_DIRS-1:0] raw_vec;
  logic [NUM_DIRS-1:0] pulse_vec;

  assign raw_vec[DIR_L] = btn_l_raw;
  assign raw_vec[DIR_R] = btn_r_raw;
  assign raw_vec[DIR_U] = btn_u_raw;
  assign raw_vec[DIR_D] = btn_d_raw;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[i]),
      .pulse(pulse_vec[i]),
      .level(btn_level[i])
    );
  end

  assign btn_l = pulse_vec[DIR_L];
  assign btn_r = pulse_vec[DIR_R];
  assign btn_u = pulse_vec[DIR_U];
  assign btn_d = pulse_vec[DIR_D];

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: a run-length/elapsed-time model checked every cycle,
// plus literal pulse-time expectations for the directed scenarios.
module tb_btn_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk;
  logic rst_n;
  logic l_raw, r_raw, u_raw, d_raw;
  logic btn_l, btn_r, btn_u, btn_d;
  logic [3:0] btn_level;
  logic nr_l, nr_r, nr_u, nr_d;
  logic [3:0] nr_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_l_raw(l_raw), .btn_r_raw(r_raw), .btn_u_raw(u_raw), .btn_d_raw(d_raw),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_level(btn_level));

  btn_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_nr (
    .clk(clk), .rst_n(rst_n),
    .btn_l_raw(l_raw), .btn_r_raw(r_raw), .btn_u_raw(u_raw), .btn_d_raw(d_raw),
    .btn_l(nr_l), .btn_r(nr_r), .btn_u(nr_u), .btn_d(nr_d), .btn_level(nr_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] raw_vec;
  assign raw_vec = {d_raw, u_raw, r_raw, l_raw};

  // Model: indices 0-3 are the repeating instance, 4-7 the non-repeating one.
  // A level change is accepted once the synced input has disagreed with the
  // accepted level for D+1 consecutive edges; repeats are timed from HELD entry.
  bit mp1[8], mp2[8], mlast[8], mlvl[8], mheld[8], mpulse[8];
  int mrun[8], mt0[8];
  int mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk <= 0;
      for (int i = 0; i < 8; i++) begin
        mp1[i] <= 0; mp2[i] <= 0; mlast[i] <= 0; mlvl[i] <= 0;
        mheld[i] <= 0; mpulse[i] <= 0; mrun[i] <= 0; mt0[i] <= 0;
      end
    end else begin
      mk <= mk + 1;
      for (int i = 0; i < 8; i++) begin
        automatic bit s  = mp2[i];
        automatic int r  = (s == mlast[i]) ? mrun[i] + 1 : 1;
        automatic bit nl = mlvl[i];
        automatic bit nh = mheld[i];
        automatic bit np = 1'b0;
        automatic int nt = mt0[i];
        automatic int e  = mk - mt0[i];
        if (r > 1000) r = 1000;
        if (!mlvl[i]) begin
          if (s && r >= D + 1) begin
            nl = 1; nh = 1; nt = mk; np = 1;
          end
        end else if (mheld[i]) begin
          if (!s) nh = 0;
          else if (i < 4 && (e == RD || (e > RD && (e - RD) % RP == 0))) np = 1;
        end else begin
          if (s) begin
            nh = 1; nt = mk;
          end else if (r >= D + 1) begin
            nl = 0;
          end
        end
        mp1[i] <= raw_vec[i % 4];
        mp2[i] <= mp1[i];
        mlast[i] <= s;
        mrun[i] <= r;
        mlvl[i] <= nl;
        mheld[i] <= nh;
        mpulse[i] <= np;
        mt0[i] <= nt;
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %b want %b", nm, cyc, act, exp_v);
    end
  endtask

  function automatic string q2s(input int q[$]);
    string s;
    s = "{";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return {s, " }"};
  endfunction

  task automatic chk_q(input string nm, input int act[$], input int exp_q[$]);
    bit ok;
    ok = (act.size() == exp_q.size());
    if (ok) foreach (act[i]) if (act[i] != exp_q[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s want %s", nm, q2s(act), q2s(exp_q));
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ep, el, enp, enl;
    for (int i = 0; i < 4; i++) begin
      ep[i] = mpulse[i]; el[i] = mlvl[i];
      enp[i] = mpulse[i+4]; enl[i] = mlvl[i+4];
    end
    chk("pulse", {btn_d, btn_u, btn_r, btn_l}, ep);
    chk("level", btn_level, el);
    chk("nr_pulse", {nr_d, nr_u, nr_r, nr_l}, enp);
    chk("nr_level", nr_level, enl);
  end

  // Pulse times relative to the scenario's edge 0
  int q_l[$], q_r[$], q_u[$], q_d[$], q_nl[$];
  int u_lvl_hi;

  always @(negedge clk) begin
    if (btn_l) q_l.push_back(cyc - base);
    if (btn_r) q_r.push_back(cyc - base);
    if (btn_u) q_u.push_back(cyc - base);
    if (btn_d) q_d.push_back(cyc - base);
    if (nr_l)  q_nl.push_back(cyc - base);
    if (btn_level[2]) u_lvl_hi++;
  end

  task automatic start();
    @(negedge clk);
    base = cyc + 1;
    q_l.delete(); q_r.delete(); q_u.delete(); q_d.delete(); q_nl.delete();
    u_lvl_hi = 0;
  endtask

  task automatic wait_until(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    l_raw = 0; r_raw = 0; u_raw = 0; d_raw = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", btn_level, 4'b0000);
    chk("reset_pulse", {btn_d, btn_u, btn_r, btn_l}, 4'b0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: clean press of r held 10 cycles
    start(); r_raw = 1;
    wait_until(5);  chk("s1_pre_pulse", {btn_d, btn_u, btn_r, btn_l}, 4'b0000);
    wait_until(6);  chk("s1_pulse", {btn_d, btn_u, btn_r, btn_l}, 4'b0010);
    chk("s1_level_on", btn_level, 4'b0010);
    wait_until(9);  r_raw = 0;
    wait_until(15); chk("s1_level_hold", btn_level, 4'b0010);
    wait_until(16); chk("s1_level_off", btn_level, 4'b0000);
    wait_until(30);
    e = {6}; chk_q("s1_r", q_r, e);
    e = {};  chk_q("s1_l", q_l, e); chk_q("s1_u", q_u, e); chk_q("s1_d", q_d, e);

    // 2: bounce on u shorter than debounce
    start(); u_raw = 1;
    wait_until(1); u_raw = 0;
    wait_until(3); u_raw = 1;
    wait_until(5); u_raw = 0;
    wait_until(30);
    e = {}; chk_q("s2_u", q_u, e);
    chk("s2_level_hi_cycles", 4'(u_lvl_hi), 4'd0);

    // 3: l held 50 cycles, repeat on and off
    start(); l_raw = 1;
    wait_until(49); l_raw = 0;
    wait_until(70);
    e = {6, 26, 34, 42, 50}; chk_q("s3_l", q_l, e);
    e = {6};                 chk_q("s3_nr_l", q_nl, e);

    // 4: d dropped 2 cycles while held; repeat timer restarts on re-entry
    start(); d_raw = 1;
    wait_until(9);  d_raw = 0;
    wait_until(11); d_raw = 1;
    wait_until(51); d_raw = 0;
    wait_until(75);
    e = {6, 34, 42, 50}; chk_q("s4_d", q_d, e);

    // 5: l and r together
    start(); l_raw = 1; r_raw = 1;
    wait_until(7); l_raw = 0; r_raw = 0;
    wait_until(30);
    e = {6}; chk_q("s5_l", q_l, e); chk_q("s5_r", q_r, e);

    // 6: reset pulse while u is held
    start(); u_raw = 1;
    wait_until(12);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("s6_async_level", btn_level, 4'b0000);
    chk("s6_async_pulse", {btn_d, btn_u, btn_r, btn_l}, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1;
    base = cyc + 1;
    q_u.delete();
    wait_until(6);  chk("s6_level", btn_level, 4'b0100);
    wait_until(20); u_raw = 0;
    wait_until(40);
    e = {6}; chk_q("s6_u", q_u, e);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
